seq_divider_ctrl: RTL and testbench



---
 rtl/seq_divider_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_divider_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_ctrl.sv
// Iterative restoring divider, one quotient bit per cycle, start/done handshake.
// Signed operation is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider_ctrl #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;      // dividend bits shift out, quotient bits shift in
    logic [W-1:0]  p_q;      // partial remainder
    logic [W-1:0]  b_q;      // divisor magnitude
    logic [CW-1:0] cnt_q;
    logic          dz_q;

    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          ge;
    logic [W-1:0]  p_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic [W-1:0]  dvd_q;
    logic          neg_q_q;
    logic          neg_r_q;
    logic          sgn_a;
    logic          sgn_b;

    always_comb begin
        sgn_a = signed_mode & dividend[W-1];
        sgn_b = signed_mode & divisor[W-1];
        mag_a = sgn_a ? (-dividend) : dividend;
        mag_b = sgn_b ? (-divisor) : divisor;
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;

    always_comb begin
        mag_a = dividend;
        mag_b = divisor;
    end
`endif

    // W+1-bit compare: the shifted partial remainder can exceed W bits
    always_comb begin
        shifted = {p_q, a_q[W-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = (shifted >= {1'b0, b_q});
        p_d     = ge ? diff[W-1:0] : shifted[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_q       <= '0;
            p_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            dvd_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        done      <= 1'b1;
                        quotient  <= a_q;
                        remainder <= p_q;
                        div_zero  <= dz_q;
                    end
                    if (start) begin
                        a_q     <= mag_a;
                        b_q     <= mag_b;
                        p_q     <= '0;
                        cnt_q   <= CW'(W - 1);
                        dz_q    <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        dvd_q   <= dividend;
                        neg_q_q <= sgn_a ^ sgn_b;
                        neg_r_q <= sgn_a;
`endif
                        busy    <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q   <= {a_q[W-2:0], ge};
                    p_q   <= p_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    // Divide-by-zero bypasses the sign fix and returns the raw dividend
                    if (dz_q) begin
                        a_q <= '1;
                        p_q <= dvd_q;
                    end else begin
                        a_q <= neg_q_q ? (-a_q) : a_q;
                        p_q <= neg_r_q ? (-p_q) : p_q;
                    end
`endif
                    busy    <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl (W=5): vector table, corner sequences, random sweep.
module tb_seq_divider_ctrl;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int unsigned LAT = 7;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [4:0] dividend = '0;
    logic [4:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_zero;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] q;
        logic [4:0] r;
        logic       dz;
    } exp_t;

    typedef struct {
        logic       sm;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] q_s;
        logic [4:0] r_s;
        logic [4:0] q_u;
        logic [4:0] r_u;
        logic       dz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    seq_divider_ctrl #(.W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sm, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        logic signed [4:0] sa;
        logic signed [4:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 5'd0) begin
            e.q  = 5'b11111;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sm && SIGNED_EN) begin
            e.q  = sa / sbv;
            e.r  = sa % sbv;
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Call #1 after a rising edge; returns #1 after the edge that accepts start.
    task automatic issue(input logic sm, input logic [4:0] a, input logic [4:0] b, input exp_t e);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input bit pulse_start);
        int   lat;
        exp_t e;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (pulse_start && (i == 2 || i == 3)) begin
                start       = 1'b1;
                signed_mode = 1'($urandom_range(0, 1));
                dividend    = 5'($urandom);
                divisor     = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, LAT);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("quotient", {27'd0, quotient}, {27'd0, e.q});
            check("remainder", {27'd0, remainder}, {27'd0, e.r});
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        end
    endtask

    initial begin
        exp_t e;
        exp_t held;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       rsm;

        //            sm    a         b         q_s       r_s       q_u       r_u       dz
        vecs[0]  = '{1'b1, 5'b11111, 5'b00011, 5'b00000, 5'b11111, 5'b01010, 5'b00001, 1'b0};
        vecs[1]  = '{1'b0, 5'b11111, 5'b00011, 5'b01010, 5'b00001, 5'b01010, 5'b00001, 1'b0};
        vecs[2]  = '{1'b1, 5'b10000, 5'b11111, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 1'b0};
        vecs[3]  = '{1'b1, 5'b10110, 5'b00011, 5'b11101, 5'b11111, 5'b00111, 5'b00001, 1'b0};
        vecs[4]  = '{1'b0, 5'b00110, 5'b00000, 5'b11111, 5'b00110, 5'b11111, 5'b00110, 1'b1};
        vecs[5]  = '{1'b1, 5'b00110, 5'b00000, 5'b11111, 5'b00110, 5'b11111, 5'b00110, 1'b1};
        vecs[6]  = '{1'b1, 5'b10110, 5'b00000, 5'b11111, 5'b10110, 5'b11111, 5'b10110, 1'b1};
        vecs[7]  = '{1'b0, 5'd20,    5'd4,     5'd5,     5'd0,     5'd5,     5'd0,     1'b0};
        vecs[8]  = '{1'b1, 5'b01101, 5'b11011, 5'b11110, 5'b00011, 5'b00000, 5'b01101, 1'b0};
        vecs[9]  = '{1'b1, 5'b10011, 5'b00101, 5'b11110, 5'b11101, 5'b00011, 5'b00100, 1'b0};
        vecs[10] = '{1'b0, 5'd1,     5'd1,     5'd1,     5'd0,     5'd1,     5'd0,     1'b0};
        vecs[11] = '{1'b1, 5'b01111, 5'b00001, 5'b01111, 5'b00000, 5'b01111, 5'b00000, 1'b0};

        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", {27'd0, quotient}, 32'd0);
        check("reset_remainder", {27'd0, remainder}, 32'd0);
        check("reset_div_zero", {31'd0, div_zero}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            e.q  = (vecs[i].sm && SIGNED_EN) ? vecs[i].q_s : vecs[i].q_u;
            e.r  = (vecs[i].sm && SIGNED_EN) ? vecs[i].r_s : vecs[i].r_u;
            e.dz = vecs[i].dz;
            issue(vecs[i].sm, vecs[i].a, vecs[i].b, e);
            wait_done(1'b0);
            @(posedge clk); #1;
        end

        // Results hold and done is a single pulse
        held.q = quotient;
        held.r = remainder;
        repeat (3) @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("hold_quotient", {27'd0, quotient}, 32'd15);
        check("hold_remainder", {27'd0, remainder}, 32'd0);

        // Back-to-back: second start issued in the done cycle
        e = '{5'd3, 5'd1, 1'b0};
        issue(1'b0, 5'd10, 5'd3, e);
        wait_done(1'b0);
        e = '{5'd5, 5'd0, 1'b0};
        issue(1'b0, 5'd20, 5'd4, e);
        wait_done(1'b0);

        // Start pulses during CALC must not disturb the running division
        e = model(1'b1, 5'b10110, 5'b00011);
        issue(1'b1, 5'b10110, 5'b00011, e);
        wait_done(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("no_spurious_done", {31'd0, done}, 32'd0);

        // Reset in the middle of CALC
        e = '{5'd1, 5'd2, 1'b0};
        issue(1'b0, 5'd9, 5'd7, e);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sb.delete();
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_quotient", {27'd0, quotient}, 32'd0);
        check("midreset_remainder", {27'd0, remainder}, 32'd0);
        check("midreset_div_zero", {31'd0, div_zero}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("midreset_idle_no_done", {31'd0, done}, 32'd0);
        e = '{5'd4, 5'd1, 1'b0};
        issue(1'b0, 5'd13, 5'd3, e);
        wait_done(1'b0);

        for (int i = 0; i < 24; i++) begin
            rsm = 1'($urandom_range(0, 1));
            ra  = 5'($urandom);
            rb  = (i % 8 == 0) ? 5'd0 : 5'($urandom);
            issue(rsm, ra, rb, model(rsm, ra, rb));
            wait_done(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
